hall98_fetch_decode: RTL
========================

// Module: hall98_fetch_decode
// PURPOSE
// - Front end of the HALL98 core: fetches 32-bit instruction words from instruction memory and buffers them in a prefetch FIFO.
// - Decodes each word into the execute stage's operand bus (sw1, sw2, flag, re, n) and issues at most one instruction per cycle.
// - Sits directly upstream of the HALL98 execute stage and owns the program counter and the halt state.
// PARAMETERS
// - AW      8  instruction address width, in words; PC wraps modulo 2^AW
// - DEPTH   4  prefetch FIFO entries (power of 2, >=2)
// PORTS
// - iclock      in   1   clock, rising edge
// - irst        in   1   asynchronous active-high reset
// - start       in   1   pulse: load PC from start_pc, begin fetching (honoured in IDLE/HALT only)
// - start_pc    in   AW  first fetch address
// - imem_req    out  1   read request; held high until imem_ack
// - imem_addr   out  AW  word address; stable while imem_req high
// - imem_ack    in   1   read data valid this cycle (same cycle as req or later)
// - imem_rdata  in   32  instruction word
// - issue_ready in   1   execute stage accepts this cycle (tie 1 for the current execute stage)
// - sw1, sw2    out  1   opcode {sw1,sw2}: 00 mul, 01 add, 10 mov, 11 sub
// - flag        out  1   0 = operate; 1 = bubble/no-op in the execute stage
// - re          out  32  destination register index (1 H, 2 A, 3 L, 4 N)
// - n           out  32  source register index, or zero-extended immediate for mov
// - issue_valid out  1   a real instruction is on the operand bus
// - halted      out  1   HALT state reached
// - pc_out      out  AW  address of the next word to fetch
// BEHAVIOUR
// - Word format: [31:30] op, [29] halt, [28:26] re, [25:0] n (zero-extended to 32 bits).
// - Reset values: imem_req=0, imem_addr=0, pc_out=0, issue_valid=0, flag=1, sw1=sw2=0, re=0, n=0, halted=0; FIFO empty; no request outstanding.
// - FSM states: IDLE -> (start) FETCH -> (halt word dequeued) DRAIN -> (FIFO empty) HALT -> (start) FETCH.
// - FETCH: one request outstanding at most; raise imem_req only when FIFO count + outstanding < DEPTH. On ack: push rdata, PC+1 with wrap at 2^AW, and the next request may assert in the following cycle.
// - The halt bit is decoded when a word is pushed. After a halt word is pushed, no further requests are made, and the halt word itself is not issued.
// - DRAIN issues the remaining FIFO entries that precede the halt word. HALT sets halted=1 and holds issue_valid=0.
// - Issue is registered. When the FIFO is non-empty and (issue_ready or !issue_valid), the head is dequeued into the output regs with issue_valid=1 and flag=0. Otherwise, if issue_ready, the outputs become a bubble: issue_valid=0, flag=1, other fields unchanged.
// - If issue_ready=0, all outputs hold.
// - Latency: ack in cycle t -> issue_valid in cycle t+1 when the FIFO was empty.
// - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
// - A start pulse while in FETCH or DRAIN is ignored.
// - An ack while no request is outstanding is ignored (covers a late ack after reset).
// - Reset mid-operation abandons the outstanding request immediately; the FIFO is flushed.
// CONFIGURATION
// - HALL98_FD_ILLEGAL_CHK_EN defined: a dequeued word with re not in 1..4, or with flag-source (op!=mov) n[25:0] not in 1..4, is dropped. It issues as a bubble, and output illegal (1 bit, 1-cycle pulse) asserts.
// - Without the macro: no illegal port, and such words are issued unchanged.
// STRUCTURE
// - Package hall98_pkg: op constants (OP_MUL=2'b00, OP_ADD=2'b01, OP_MOV=2'b10, OP_SUB=2'b11), register index constants (REG_H=1..REG_N=4), instruction field bit positions, fetch state enum.
// - One sub-module: hall98_prefetch_fifo (DEPTH x 32, push/pop/full/empty/count; simultaneous push+pop when full).
// TESTING
// - Reset, start_pc=0, ROM {mov A,#5; add A,A; halt}, ack same cycle -> issues (10,re=2,n=5) then (01,re=2,n=2); halted=1; exactly 2 issue_valid cycles.
// - ack delayed 3 cycles per request -> imem_addr stable while req high; a single outstanding request; same issue sequence.
// - issue_ready=0 for 6 cycles with 5+ words available -> FIFO fills to 4, imem_req drops, outputs hold; release -> 4 back-to-back issues in order.
// - AW=8, start_pc=255 -> fetch addresses 255 then 0 (wrap); pc_out=1 after the second ack.
// - Assert irst while a request is outstanding, then ack 2 cycles later -> all outputs at reset values, late ack ignored, FIFO empty.
// - With HALL98_FD_ILLEGAL_CHK_EN, word with re=7 -> illegal pulses 1 cycle, flag=1 that cycle, next word issues normally.

Source files
------------

// File: rtl/hall98_pkg.sv
// Shared definitions for the HALL98 fetch/decode front end: opcode and register
// encodings, instruction field positions, fetch FSM states.
package hall98_pkg;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam logic [2:0] REG_H = 3'd1;
    localparam logic [2:0] REG_A = 3'd2;
    localparam logic [2:0] REG_L = 3'd3;
    localparam logic [2:0] REG_N = 3'd4;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 30;
    localparam int HALT_BIT = 29;
    localparam int RE_HI    = 28;
    localparam int RE_LO    = 26;
    localparam int N_HI     = 25;
    localparam int N_LO     = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_HALT
    } fetch_state_t;

    // Halt bit is consumed at push time, so a buffered entry carries only these fields.
    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  re;
        logic [25:0] n;
    } fifo_entry_t;

    function automatic logic entry_is_legal(input fifo_entry_t e);
        logic re_ok;
        logic n_ok;
        re_ok = (e.re >= REG_H) && (e.re <= REG_N);
        n_ok  = (e.n >= 26'(REG_H)) && (e.n <= 26'(REG_N));
        entry_is_legal = re_ok && ((e.op == OP_MOV) || n_ok);
    endfunction

endpackage

// File: rtl/hall98_fetch_decode_if.sv
// Instruction-memory read port and execute-stage operand bus of the HALL98 front end.
// HALL98_FD_ILLEGAL_CHK_EN adds the illegal-word pulse.
interface hall98_fetch_decode_if #(
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;

    logic          issue_ready;
    logic          sw1;
    logic          sw2;
    logic          flag;
    logic [31:0]   re;
    logic [31:0]   n;
    logic          issue_valid;
`ifdef HALL98_FD_ILLEGAL_CHK_EN
    logic          illegal;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, issue_ready,
        output sw1, sw2, flag, re, n, issue_valid, illegal
    );
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, issue_ready,
        input  sw1, sw2, flag, re, n, issue_valid, illegal
    );
`else
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, issue_ready,
        output sw1, sw2, flag, re, n, issue_valid
    );
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, issue_ready,
        input  sw1, sw2, flag, re, n, issue_valid
    );
`endif
endinterface

// File: rtl/hall98_prefetch_fifo.sv
// Prefetch buffer: DEPTH x W circular FIFO with occupancy count; push and pop
// in the same cycle are accepted even when full.
module hall98_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   iclock,
    input  logic                   irst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge iclock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge iclock or posedge irst) begin
        if (irst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hall98_fetch_decode.sv
// HALL98 front end: fetches words into the prefetch FIFO and issues decoded operands.
// HALL98_FD_ILLEGAL_CHK_EN enables dropping of undecodable words with an illegal pulse.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | after reset; waits for start
//   ST_FETCH | requesting words while the FIFO has room
//   ST_DRAIN | halt word fetched; issuing what was buffered ahead of it
//   ST_HALT  | FIFO empty, halted=1; start re-enters FETCH
module hall98_fetch_decode
    import hall98_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                  iclock,
    input  logic                  irst,
    input  logic                  start,
    input  logic [AW-1:0]         start_pc,
    hall98_fetch_decode_if.master bus,
    output logic                  halted,
    output logic [AW-1:0]         pc_out
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nx;
    logic [AW-1:0] pc;
    logic          accept;
    logic          halt_word;
    logic          push_req;
    logic          avail;
    logic          take;
    logic          bypass;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fifo_entry_t   in_entry;
    fifo_entry_t   head;
    fifo_entry_t   src;

    // Only one request is ever outstanding, so the FIFO only needs one free slot.
    assign bus.imem_req  = (state == ST_FETCH) && !fifo_full;
    assign bus.imem_addr = pc;
    assign pc_out        = pc;
    assign halted        = (state == ST_HALT);

    assign accept      = bus.imem_req && bus.imem_ack;
    assign halt_word   = accept && bus.imem_rdata[HALT_BIT];
    assign push_req    = accept && !halt_word;
    assign in_entry.op = bus.imem_rdata[OP_HI:OP_LO];
    assign in_entry.re = bus.imem_rdata[RE_HI:RE_LO];
    assign in_entry.n  = bus.imem_rdata[N_HI:N_LO];

    // An arriving word bypasses an empty FIFO to meet the one-cycle ack-to-issue latency.
    assign avail     = push_req || !fifo_empty;
    assign take      = avail && (bus.issue_ready || !bus.issue_valid);
    assign bypass    = take && fifo_empty;
    assign fifo_push = push_req && !bypass;
    assign fifo_pop  = take && !fifo_empty;
    assign src       = fifo_empty ? in_entry : head;

    hall98_prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .iclock (iclock),
        .irst   (irst),
        .push   (fifo_push),
        .wdata  (in_entry),
        .pop    (fifo_pop),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge iclock or posedge irst) begin
        if (irst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)              state_nx = ST_FETCH;
            ST_FETCH: if (halt_word)          state_nx = ST_DRAIN;
            ST_DRAIN: if (fifo_count == '0)   state_nx = ST_HALT;
            ST_HALT:  if (start)              state_nx = ST_FETCH;
            default:                          state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclock or posedge irst) begin
        if (irst) begin
            pc <= '0;
        end else if (start && ((state == ST_IDLE) || (state == ST_HALT))) begin
            pc <= start_pc;
        end else if (accept) begin
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge iclock or posedge irst) begin
        if (irst) begin
            bus.sw1         <= 1'b0;
            bus.sw2         <= 1'b0;
            bus.flag        <= 1'b1;
            bus.re          <= '0;
            bus.n           <= '0;
            bus.issue_valid <= 1'b0;
`ifdef HALL98_FD_ILLEGAL_CHK_EN
            bus.illegal     <= 1'b0;
`endif
        end else begin
`ifdef HALL98_FD_ILLEGAL_CHK_EN
            bus.illegal <= 1'b0;
`endif
            if (take) begin
`ifdef HALL98_FD_ILLEGAL_CHK_EN
                if (!entry_is_legal(src)) begin
                    bus.issue_valid <= 1'b0;
                    bus.flag        <= 1'b1;
                    bus.illegal     <= 1'b1;
                end else begin
                    {bus.sw1, bus.sw2} <= src.op;
                    bus.re             <= 32'(src.re);
                    bus.n              <= 32'(src.n);
                    bus.issue_valid    <= 1'b1;
                    bus.flag           <= 1'b0;
                end
`else
                {bus.sw1, bus.sw2} <= src.op;
                bus.re             <= 32'(src.re);
                bus.n              <= 32'(src.n);
                bus.issue_valid    <= 1'b1;
                bus.flag           <= 1'b0;
`endif
            end else if (bus.issue_ready) begin
                bus.issue_valid <= 1'b0;
                bus.flag        <= 1'b1;
            end
        end
    end

endmodule
